// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbiter: output stage state and an id width helper.
package arb_pkg;

  typedef enum logic [0:0] {
    e_arb_empty = 1'b0,
    e_arb_full  = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits, so a single requester still has an id port.
  function automatic int safe_clog2(input int n);
    int r;
    r = (n > 1) ? $clog2(n) : 1;
    return r;
  endfunction

endpackage

// File: rtl/bsg_scan.sv
// Parallel prefix scan (OR / AND / XOR) over a bit vector, either direction.
module bsg_scan #(
  parameter int width_p    = 1,
  parameter int and_p      = 0,
  parameter int or_p       = 0,
  parameter int xor_p      = 0,
  parameter int lo_to_hi_p = 0
) (
  input  logic [width_p-1:0] i,
  output logic [width_p-1:0] o
);

  logic [width_p-1:0] in_ord_s;
  logic [width_p-1:0] out_ord_s;
  logic               acc_s;

  // Present the input so the scan always runs from bit 0 upward.
  always_comb begin
    in_ord_s = '0;
    for (int k = 0; k < width_p; k++) begin
      if (lo_to_hi_p != 0) begin
        in_ord_s[k] = i[k];
      end else begin
        in_ord_s[k] = i[width_p-1-k];
      end
    end
  end

  // Running accumulation with the selected reduction operator.
  always_comb begin
    out_ord_s = '0;
    acc_s     = in_ord_s[0];
    out_ord_s[0] = acc_s;
    for (int k = 1; k < width_p; k++) begin
      if (and_p != 0) begin
        acc_s = acc_s & in_ord_s[k];
      end else if (xor_p != 0) begin
        acc_s = acc_s ^ in_ord_s[k];
      end else begin
        acc_s = acc_s | in_ord_s[k];
      end
      out_ord_s[k] = acc_s;
    end
  end

  // Undo the ordering applied on the way in.
  always_comb begin
    o = '0;
    for (int k = 0; k < width_p; k++) begin
      if (lo_to_hi_p != 0) begin
        o[k] = out_ord_s[k];
      end else begin
        o[width_p-1-k] = out_ord_s[k];
      end
    end
  end

endmodule

// File: rtl/scan_rr_arb.sv
// Round-robin arbiter feeding a one-entry registered output stage; the winner is
// found with two low-to-high OR scans (requests above the last grant, then all requests).
module scan_rr_arb
  import arb_pkg::*;
#(
  parameter int width_p      = 4,
  parameter int data_width_p = 32
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [width_p-1:0]              v_i,
  input  logic [width_p*data_width_p-1:0] data_i,
  output logic [width_p-1:0]              yumi_o,
  output logic                            v_o,
  output logic [data_width_p-1:0]         data_o,
  output logic [safe_clog2(width_p)-1:0]  grant_id_o,
  input  logic                            ready_i
);

  localparam int id_width_lp = safe_clog2(width_p);

  arb_state_e              state_r;
  logic [data_width_p-1:0] data_r;
  logic [id_width_lp-1:0]  grant_id_r;
  logic [id_width_lp-1:0]  last_r;

  logic [width_p-1:0]      mask_s;
  logic [width_p-1:0]      masked_s;
  logic [width_p-1:0]      scan_m_s;
  logic [width_p-1:0]      scan_u_s;
  logic [width_p-1:0]      onehot_m_s;
  logic [width_p-1:0]      onehot_u_s;
  logic [width_p-1:0]      sel_s;
  logic [id_width_lp-1:0]  win_id_s;
  logic [data_width_p-1:0] win_data_s;
  logic                    take_s;
  logic                    grant_s;

  // Keep only requesters strictly above the last granted index.
  always_comb begin
    mask_s = '0;
    for (int k = 0; k < width_p; k++) begin
      mask_s[k] = (k > int'(last_r)) ? 1'b1 : 1'b0;
    end
  end

  assign masked_s = v_i & mask_s;

  bsg_scan #(
    .width_p    (width_p),
    .or_p       (1),
    .lo_to_hi_p (1)
  ) scan_masked (
    .i (masked_s),
    .o (scan_m_s)
  );

  bsg_scan #(
    .width_p    (width_p),
    .or_p       (1),
    .lo_to_hi_p (1)
  ) scan_unmasked (
    .i (v_i),
    .o (scan_u_s)
  );

  assign onehot_m_s = scan_m_s & ~(scan_m_s << 1);
  assign onehot_u_s = scan_u_s & ~(scan_u_s << 1);

  // Fall back to the unmasked winner when nothing sits above the pointer (wrap-around).
  always_comb begin
    if (|masked_s) begin
      sel_s = onehot_m_s;
    end else begin
      sel_s = onehot_u_s;
    end
  end

  // One-hot to index and payload selection, both as AND-OR reductions.
  always_comb begin
    win_id_s   = '0;
    win_data_s = '0;
    for (int k = 0; k < width_p; k++) begin
      win_id_s   = win_id_s | (sel_s[k] ? id_width_lp'(k) : {id_width_lp{1'b0}});
      win_data_s = win_data_s
                 | (data_i[k*data_width_p +: data_width_p] & {data_width_p{sel_s[k]}});
    end
  end

  assign take_s  = (state_r == e_arb_empty) | ready_i;
  assign grant_s = reset_n_i & take_s & (|v_i);
  assign yumi_o  = grant_s ? sel_s : {width_p{1'b0}};

  // Output stage and round-robin pointer.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_arb_empty;
      data_r     <= '0;
      grant_id_r <= '0;
      last_r     <= id_width_lp'(width_p - 1);
    end else begin
      case (state_r)
        e_arb_empty: begin
          if (grant_s) begin
            state_r    <= e_arb_full;
            data_r     <= win_data_s;
            grant_id_r <= win_id_s;
            last_r     <= win_id_s;
          end else begin
            state_r <= e_arb_empty;
          end
        end
        e_arb_full: begin
          if (grant_s) begin
            state_r    <= e_arb_full;
            data_r     <= win_data_s;
            grant_id_r <= win_id_s;
            last_r     <= win_id_s;
          end else if (ready_i) begin
            state_r <= e_arb_empty;
          end else begin
            state_r <= e_arb_full;
          end
        end
        default: begin
          state_r <= e_arb_empty;
        end
      endcase
    end
  end

  assign v_o        = (state_r == e_arb_full);
  assign data_o     = data_r;
  assign grant_id_o = grant_id_r;

endmodule

// File: tb/tb_scan_rr_arb.sv
// Directed self-checking bench for scan_rr_arb (width_p=4, data_width_p=32).
module tb_scan_rr_arb;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   v;
  logic [127:0] data;
  logic [3:0]   yumi;
  logic         v_out;
  logic [31:0]  data_out;
  logic [1:0]   gid;
  logic         ready;

  int total = 0;
  int bad   = 0;

  scan_rr_arb #(.width_p(4), .data_width_p(32)) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .v_i        (v),
    .data_i     (data),
    .yumi_o     (yumi),
    .v_o        (v_out),
    .data_o     (data_out),
    .grant_id_o (gid),
    .ready_i    (ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pay(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; v = 4'b1111; ready = 1'b1;
    #2;
    total++; if (yumi !== 4'b0000) begin bad++; $display("FAIL reset_yumi got=%b want=0000", yumi); end
    total++; if (v_out !== 1'b0) begin bad++; $display("FAIL reset_v got=%b want=0", v_out); end
    total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", data_out); end
    total++; if (gid !== 2'd0) begin bad++; $display("FAIL reset_gid got=%0d want=0", gid); end
    tick;
    total++; if (v_out !== 1'b0) begin bad++; $display("FAIL reset_v_clk got=%b want=0", v_out); end
    reset_n = 1'b1;
  endtask

  task automatic test_rotation;
    int e;
    v = 4'b1111; ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      e = i % 4;
      #1;
      total++; if (yumi !== 4'(4'b0001 << e)) begin bad++; $display("FAIL rot_yumi[%0d] got=%b want_idx=%0d", i, yumi, e); end
      tick;
      total++; if (v_out !== 1'b1) begin bad++; $display("FAIL rot_v[%0d] got=%b want=1", i, v_out); end
      total++; if (gid !== 2'(e)) begin bad++; $display("FAIL rot_gid[%0d] got=%0d want=%0d", i, gid, e); end
      total++; if (data_out !== pay(e)) begin bad++; $display("FAIL rot_data[%0d] got=%h want=%h", i, data_out, pay(e)); end
    end
  endtask

  task automatic test_single;
    v = 4'b0100; ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (yumi !== 4'b0100) begin bad++; $display("FAIL single_yumi[%0d] got=%b want=0100", i, yumi); end
      tick;
      total++; if (gid !== 2'd2 || v_out !== 1'b1) begin bad++; $display("FAIL single_gid[%0d] got=%0d/%b want=2/1", i, gid, v_out); end
    end
  endtask

  task automatic test_stall;
    v = 4'b0010; ready = 1'b1;
    #1;
    total++; if (yumi !== 4'b0010) begin bad++; $display("FAIL stall_pre_yumi got=%b want=0010", yumi); end
    tick;
    total++; if (gid !== 2'd1) begin bad++; $display("FAIL stall_pre_gid got=%0d want=1", gid); end
    v = 4'b1111; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (yumi !== 4'b0000) begin bad++; $display("FAIL stall_yumi[%0d] got=%b want=0000", i, yumi); end
      tick;
      total++; if (gid !== 2'd1 || data_out !== pay(1) || v_out !== 1'b1) begin
        bad++; $display("FAIL stall_hold[%0d] got=%0d/%h/%b want=1/%h/1", i, gid, data_out, v_out, pay(1));
      end
    end
    ready = 1'b1;
    #1;
    total++; if (yumi !== 4'b0100) begin bad++; $display("FAIL stall_release_yumi got=%b want=0100", yumi); end
    tick;
    total++; if (gid !== 2'd2) begin bad++; $display("FAIL stall_release_gid got=%0d want=2", gid); end
  endtask

  task automatic test_wrap;
    logic [3:0] vin [3]  = '{4'b1000, 4'b1001, 4'b1001};
    logic [3:0] ey  [3]  = '{4'b1000, 4'b0001, 4'b1000};
    logic [1:0] eid [3]  = '{2'd3, 2'd0, 2'd3};
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v = vin[i];
      #1;
      total++; if (yumi !== ey[i]) begin bad++; $display("FAIL wrap_yumi[%0d] got=%b want=%b", i, yumi, ey[i]); end
      tick;
      total++; if (gid !== eid[i]) begin bad++; $display("FAIL wrap_gid[%0d] got=%0d want=%0d", i, gid, eid[i]); end
    end
  endtask

  task automatic test_drain;
    ready = 1'b1; v = 4'b0010;
    tick;
    total++; if (gid !== 2'd1) begin bad++; $display("FAIL drain_pre_gid got=%0d want=1", gid); end
    v = 4'b0000;
    #1;
    total++; if (yumi !== 4'b0000) begin bad++; $display("FAIL drain_yumi got=%b want=0000", yumi); end
    tick;
    total++; if (v_out !== 1'b0) begin bad++; $display("FAIL drain_v got=%b want=0", v_out); end
    total++; if (gid !== 2'd1 || data_out !== pay(1)) begin bad++; $display("FAIL drain_hold got=%0d/%h want=1/%h", gid, data_out, pay(1)); end
    v = 4'b1111;
    #1;
    total++; if (yumi !== 4'b0100) begin bad++; $display("FAIL drain_ptr_yumi got=%b want=0100", yumi); end
    tick;
    total++; if (gid !== 2'd2) begin bad++; $display("FAIL drain_ptr_gid got=%0d want=2", gid); end
    v = 4'b0000;
    tick;
    v = 4'b0001; ready = 1'b0;
    #1;
    total++; if (yumi !== 4'b0001) begin bad++; $display("FAIL empty_noready_yumi got=%b want=0001", yumi); end
    tick;
    total++; if (v_out !== 1'b1 || gid !== 2'd0) begin bad++; $display("FAIL empty_noready_fill got=%b/%0d want=1/0", v_out, gid); end
  endtask

  task automatic test_async_reset;
    v = 4'b1111; ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (v_out !== 1'b0) begin bad++; $display("FAIL async_v got=%b want=0", v_out); end
    total++; if (data_out !== 32'h0 || gid !== 2'd0) begin bad++; $display("FAIL async_clear got=%h/%0d want=0/0", data_out, gid); end
    total++; if (yumi !== 4'b0000) begin bad++; $display("FAIL async_yumi got=%b want=0000", yumi); end
    tick;
    reset_n = 1'b1; ready = 1'b1;
    #1;
    total++; if (yumi !== 4'b0001) begin bad++; $display("FAIL async_first_yumi got=%b want=0001", yumi); end
    tick;
    total++; if (gid !== 2'd0 || v_out !== 1'b1) begin bad++; $display("FAIL async_first_gid got=%0d/%b want=0/1", gid, v_out); end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) data[k*32 +: 32] = pay(k);
    test_reset;
    test_rotation;
    test_single;
    test_stall;
    test_wrap;
    test_drain;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_rr_arb.md
SCAN_RR_ARB -- requirements
Module: scan_rr_arb

Interface
REQ-001 SHALL have parameter width_p, default 4, number of requesters (legal 1..16).
REQ-002 SHALL have parameter data_width_p, default 32, payload bits per requester.
REQ-003 SHALL define localparam id_width_lp = max(1, clog2(width_p)).
REQ-004 SHALL have port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port v_i, input, width_p, per-requester valid.
REQ-007 SHALL have port data_i, input, width_p*data_width_p, payload; requester k occupies slice [k*data_width_p +: data_width_p].
REQ-008 SHALL have port yumi_o, output, width_p, one-hot-or-zero consume strobe to requesters.
REQ-009 SHALL have port v_o, output, 1, output stage holds a valid granted payload.
REQ-010 SHALL have port data_o, output, data_width_p, granted payload.
REQ-011 SHALL have port grant_id_o, output, id_width_lp, index of the requester that supplied data_o.
REQ-012 SHALL have port ready_i, input, 1, downstream accepts data_o when v_o & ready_i.

Function
REQ-013 SHALL hold a one-entry registered output stage with two states: EMPTY (v_o=0) and FULL (v_o=1).
REQ-014 SHALL compute take = (state==EMPTY) | ready_i; the stage accepts a new grant only when take=1.
REQ-015 SHALL select the winner by round-robin: the priority pointer last_r names the last granted index; search order is last_r+1, last_r+2, ... wrapping to last_r.
REQ-016 SHALL implement the search as masked = v_i & bits strictly above last_r; winner = lowest set bit of masked if nonzero, else lowest set bit of v_i.
REQ-017 SHALL derive the lowest-set-bit one-hot via a low-to-high OR prefix scan: onehot = scan & ~(scan << 1).
REQ-018 SHALL assert yumi_o = onehot only when take=1 and v_i is nonzero; otherwise yumi_o = 0 (combinational, same cycle).
REQ-019 SHALL, on a yumi cycle, register data_o, grant_id_o and last_r from the winner and enter/stay FULL; v_o rises the next cycle (1-cycle latency).
REQ-020 SHALL, when FULL & ready_i with no winner, go EMPTY next cycle; data_o/grant_id_o hold their last values.
REQ-021 SHALL, when FULL & ready_i & winner, refill in the same cycle (back-to-back throughput of one grant per cycle).
REQ-022 SHALL, when FULL & ~ready_i, keep v_o, data_o, grant_id_o, last_r stable and drive yumi_o = 0.
REQ-023 SHALL leave last_r unchanged on any cycle without a yumi.
REQ-024 SHALL, for width_p=1, grant requester 0 whenever v_i[0] & take, with grant_id_o fixed at 0.

Reset
REQ-025 SHALL, while reset_n_i=0, force state=EMPTY, v_o=0, data_o=0, grant_id_o=0, last_r=width_p-1 (requester 0 first), independent of clk_i.
REQ-026 SHALL drive yumi_o=0 while reset_n_i=0; a payload in the output stage at reset assertion is discarded.
REQ-027 SHALL resume arbitration on the first rising clk_i edge after reset_n_i deasserts.

Structure
REQ-028 SHALL place the state enum (e_arb_empty, e_arb_full) in shared package arb_pkg.
REQ-029 SHALL instantiate bsg_scan (or_p=1, lo_to_hi_p=1, width_p=width_p) twice, for masked and unmasked request vectors; no other sub-module.
REQ-030 SHALL keep the one-hot-to-index encoder local to the block.

Verification
REQ-031 SHALL cover: width_p=4, v_i=1111 constant, ready_i=1 -> grant_id_o sequence 0,1,2,3,0, v_o continuous after the first cycle.
REQ-032 SHALL cover: v_i=0100 only, ready_i=1 for 5 cycles -> yumi_o=0100 every cycle, grant_id_o=2 each cycle.
REQ-033 SHALL cover: FULL with grant_id_o=1, ready_i=0 for 3 cycles with v_i=1111 -> yumi_o=0000, data_o/grant_id_o stable; ready_i=1 -> next grant is index 2.
REQ-034 SHALL cover: last grant index 3, v_i=1001 -> wrap gives index 0; then v_i=1001 -> index 3.
REQ-035 SHALL cover: reset_n_i pulsed low mid-cycle while FULL -> v_o=0 immediately (asynchronous); first grant afterwards with v_i=1111 is index 0.
REQ-036 SHALL cover: FULL, ready_i=1, v_i=0000 -> v_o=0 next cycle, state EMPTY, last_r unchanged.
